// File: rtl/channel_reduce_unit.sv
// ---------------------------------------------------------------------------
// channel_reduce_unit
//
// Purpose:
//   Streams the IN_CH channel samples of one spatial position, one sample per
//   accepted beat. It produces the channel-wise mean and the channel-wise max
//   of that position together, as the pair of maps that the spatial gate
//   concatenates. The mean is computed as a multiply by a rounded reciprocal
//   constant, so IN_CH does not have to be a power of two. The result is then
//   saturated to the signed DATA_W range.
//
// Configuration macro:
//   CHRED_ROUND_EN - when defined, the mean rounds half-up.
//                    When undefined, the mean is floored with a truncating
//                    arithmetic shift, which matches the older mean block.
//                    The max path is the same in both builds.
//
// Ports:
//   clk      in   1       single clock, all state updates on the rising edge
//   rst      in   1       synchronous active-high reset
//   i_valid  in   1       input sample valid
//   i_ready  out  1       block can accept a sample (high only while collecting)
//   i_data   in   DATA_W  signed channel sample
//   o_valid  out  1       result pair valid, held until accepted
//   o_ready  in   1       downstream accepts the result pair
//   o_mean   out  DATA_W  signed channel mean
//   o_max    out  DATA_W  signed channel max
// ---------------------------------------------------------------------------
module channel_reduce_unit #(
  parameter int DATA_W      = 8,
  parameter int IN_CH       = 8,
  parameter int ACC_W       = 32,
  parameter int RECIP_SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic signed [DATA_W-1:0] o_mean,
  output logic signed [DATA_W-1:0] o_max
);

  localparam int CNT_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int PROD_W = ACC_W + RECIP_SHIFT + 1;
  localparam int RECIP  = ((2 ** RECIP_SHIFT) + IN_CH / 2) / IN_CH;

  localparam logic signed [PROD_W-1:0] RECIP_C = PROD_W'(RECIP);
`ifdef CHRED_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND_C = PROD_W'(1) << (RECIP_SHIFT - 1);
`else
  localparam logic signed [PROD_W-1:0] RND_C = '0;
`endif
  // The lower bound is the bitwise complement of the upper bound
  // in two's complement: ~(2^(n-1)-1) == -2^(n-1).
  localparam logic signed [PROD_W-1:0] MEAN_HI = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MEAN_LO = ~MEAN_HI;

  generate
    if (IN_CH < 2) begin : g_bad_in_ch
      $error("channel_reduce_unit: IN_CH must be at least 2");
    end
    if (ACC_W < DATA_W + CNT_W) begin : g_bad_acc_w
      $error("channel_reduce_unit: ACC_W must be at least DATA_W + clog2(IN_CH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_ACC,
    S_DIV,
    S_OUT
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CNT_W-1:0]          ch_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  max_reg;
  logic                      accept;
  logic                      last_ch;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [PROD_W-1:0]  acc_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  rounded;
  logic signed [PROD_W-1:0]  quot;
  logic signed [DATA_W-1:0]  mean_sat;

  // i_ready is a pure decode of the state register.
  // This keeps o_ready from reaching the input side combinationally.
  assign i_ready    = (state == S_ACC);
  assign accept     = i_valid && i_ready;
  assign last_ch    = (ch_cnt == CNT_W'(IN_CH - 1));
  assign sample_ext = ACC_W'(i_data);

  // Mean = acc * round(2^RECIP_SHIFT / IN_CH), scaled back down.
  // PROD_W is wide enough for the worst-case product, so the multiply cannot wrap.
  assign acc_ext = PROD_W'(acc);
  assign prod    = acc_ext * RECIP_C;
  assign rounded = prod + RND_C;
  assign quot    = rounded >>> RECIP_SHIFT;

  // Saturation only matters at the extremes,
  // where rounding up can push past the most positive code.
  always_comb begin
    mean_sat = quot[DATA_W-1:0];
    if (quot > MEAN_HI) begin
      mean_sat = MEAN_HI[DATA_W-1:0];
    end else if (quot < MEAN_LO) begin
      mean_sat = MEAN_LO[DATA_W-1:0];
    end
  end

  // State register; reset drops any partial group and returns to collecting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACC;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: collect IN_CH beats, spend one cycle dividing,
  // then hold the result until downstream takes it.
  always_comb begin
    next_state = state;
    case (state)
      S_ACC: if (accept && last_ch) next_state = S_DIV;
      S_DIV: next_state = S_OUT;
      S_OUT: if (o_ready) next_state = S_OUT == state ? S_ACC : state;
      default: next_state = S_ACC;
    endcase
  end

  // Datapath. The first beat of a group loads acc and max_reg directly,
  // so nothing from the previous group leaks into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt  <= '0;
      acc     <= '0;
      max_reg <= '0;
      o_valid <= 1'b0;
      o_mean  <= '0;
      o_max   <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            if (ch_cnt == '0) begin
              acc     <= sample_ext;
              max_reg <= i_data;
            end else begin
              acc <= acc + sample_ext;
              if (i_data > max_reg) begin
                max_reg <= i_data;
              end
            end
            if (last_ch) begin
              ch_cnt <= '0;
            end else begin
              ch_cnt <= ch_cnt + CNT_W'(1);
            end
          end
        end
        S_DIV: begin
          o_mean  <= mean_sat;
          o_max   <= max_reg;
          o_valid <= 1'b1;
        end
        S_OUT: begin
          if (o_ready) begin
            o_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_reduce_unit.sv
// ---------------------------------------------------------------------------
// tb_channel_reduce_unit
//
// Drives two instances of the block:
//   - an 8-channel instance, the main target;
//   - a 6-channel instance, which exercises a non-power-of-two reciprocal.
//
// Expected result pairs are queued when a group is issued. A monitor pops and
// compares one entry each time a result handshake is visible. Stimulus changes
// just after the rising edge; all sampling is done on the falling edge.
// ---------------------------------------------------------------------------
module tb_channel_reduce_unit;

  typedef struct {
    int mean;
    int mx;
  } exp_t;

`ifdef CHRED_ROUND_EN
  localparam int MEAN_1TO8 = 5;
  localparam int MEAN_CH6  = 25;
`else
  localparam int MEAN_1TO8 = 4;
  localparam int MEAN_CH6  = 24;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              i_valid8 = 1'b0;
  logic              i_ready8;
  logic signed [7:0] i_data8  = '0;
  logic              o_valid8;
  logic              o_ready8 = 1'b1;
  logic signed [7:0] o_mean8;
  logic signed [7:0] o_max8;

  logic              i_valid6 = 1'b0;
  logic              i_ready6;
  logic signed [7:0] i_data6  = '0;
  logic              o_valid6;
  logic              o_ready6 = 1'b1;
  logic signed [7:0] o_mean6;
  logic signed [7:0] o_max6;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q8[$];
  exp_t q6[$];

  always #5 clk = ~clk;

  channel_reduce_unit #(
    .DATA_W(8), .IN_CH(8), .ACC_W(32), .RECIP_SHIFT(16)
  ) dut8 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid8), .i_ready(i_ready8), .i_data(i_data8),
    .o_valid(o_valid8), .o_ready(o_ready8),
    .o_mean(o_mean8), .o_max(o_max8)
  );

  channel_reduce_unit #(
    .DATA_W(8), .IN_CH(6), .ACC_W(32), .RECIP_SHIFT(16)
  ) dut6 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid6), .i_ready(i_ready6), .i_data(i_data6),
    .o_valid(o_valid6), .o_ready(o_ready6),
    .o_mean(o_mean6), .o_max(o_max6)
  );

  // Central comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one sample and wait, with a bounded number of cycles, until it is
  // accepted. Returns just after the accepting rising edge, leaving i_valid
  // high so consecutive calls produce back-to-back beats.
  task automatic applyStimulus(input bit sel6, input int value);
    bit done = 0;
    if (sel6) begin
      i_valid6 = 1'b1;
      i_data6  = 8'(value);
    end else begin
      i_valid8 = 1'b1;
      i_data8  = 8'(value);
    end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if ((sel6 ? i_ready6 : i_ready8) == 1'b1) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) checkOutput("input accept timeout", 0, 1);
  endtask

  task automatic sendGroup8(input int vals[8], input int emean, input int emax);
    exp_t e;
    e.mean = emean;
    e.mx   = emax;
    q8.push_back(e);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, vals[i]);
    i_valid8 = 1'b0;
  endtask

  // Scoreboard monitor. A result is consumed whenever valid and ready are
  // both high between rising edges.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid8 && o_ready8) begin
      if (q8.size() == 0) begin
        checkOutput("dut8 unexpected result", 1, 0);
      end else begin
        e = q8.pop_front();
        checkOutput("dut8 o_mean", int'(o_mean8), e.mean);
        checkOutput("dut8 o_max", int'(o_max8), e.mx);
      end
    end
    if (o_valid6 && o_ready6) begin
      if (q6.size() == 0) begin
        checkOutput("dut6 unexpected result", 1, 0);
      end else begin
        e = q6.pop_front();
        checkOutput("dut6 o_mean", int'(o_mean6), e.mean);
        checkOutput("dut6 o_max", int'(o_max6), e.mx);
      end
    end
  end

  initial begin
    int cnt;
    int vals[8];
    exp_t e6;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset o_valid", int'(o_valid8), 0);
    checkOutput("reset o_mean", int'(o_mean8), 0);
    checkOutput("reset o_max", int'(o_max8), 0);
    checkOutput("reset i_ready", int'(i_ready8), 1);
    @(posedge clk);
    #1;

    // 1..8 back-to-back; result appears one cycle after the last accept
    vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    sendGroup8(vals, MEAN_1TO8, 8);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid8) break;
      cnt++;
    end
    checkOutput("latency cycles", cnt, 1);
    @(negedge clk);
    checkOutput("single o_valid pulse", int'(o_valid8), 0);
    @(posedge clk);
    #1;

    // All -3, then all -128 (most negative code)
    vals = '{-3, -3, -3, -3, -3, -3, -3, -3};
    sendGroup8(vals, -3, -3);
    vals = '{-128, -128, -128, -128, -128, -128, -128, -128};
    sendGroup8(vals, -128, -128);

    // Backpressure: hold o_ready low for 5 cycles after o_valid rises
    repeat (4) @(posedge clk);
    #1 o_ready8 = 1'b0;
    vals = '{2, 4, 6, 8, 10, 12, 14, 16};
    sendGroup8(vals, 9, 16);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid8) break;
      cnt++;
    end
    checkOutput("backpressure o_valid seen", int'(o_valid8), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("hold o_valid", int'(o_valid8), 1);
      checkOutput("hold o_mean", int'(o_mean8), 9);
      checkOutput("hold o_max", int'(o_max8), 16);
      checkOutput("hold i_ready", int'(i_ready8), 0);
    end
    @(posedge clk);
    #1 o_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release o_valid", int'(o_valid8), 0);
    checkOutput("release i_ready", int'(i_ready8), 1);
    @(posedge clk);
    #1;

    // All-zero group right after the stalled one
    vals = '{0, 0, 0, 0, 0, 0, 0, 0};
    sendGroup8(vals, 0, 0);

    // Gapped input: i_valid drops for one cycle between beats
    vals = '{5, -7, 3, 20, -1, 0, 9, 11};
    begin
      exp_t e;
      e.mean = 5;
      e.mx   = 20;
      q8.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, vals[i]);
      i_valid8 = 1'b0;
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;

    // Reset after three accepted samples discards the partial group
    applyStimulus(1'b0, 100);
    applyStimulus(1'b0, 120);
    applyStimulus(1'b0, 110);
    i_valid8 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid-group reset o_valid", int'(o_valid8), 0);
    checkOutput("mid-group reset o_mean", int'(o_mean8), 0);
    checkOutput("mid-group reset o_max", int'(o_max8), 0);
    checkOutput("mid-group reset i_ready", int'(i_ready8), 1);
    @(posedge clk);
    #1;

    // Fresh group after the abort
    vals = '{7, 7, 7, 7, 7, 7, 7, 7};
    sendGroup8(vals, 7, 7);

    // Six-channel instance: 10,20,30,40,50,-2 with sum 148
    e6.mean = MEAN_CH6;
    e6.mx   = 50;
    q6.push_back(e6);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b1, 40);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b1, -2);
    i_valid6 = 1'b0;

    // Drain both scoreboards, with a bound on the wait
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (q8.size() == 0 && q6.size() == 0) break;
    end
    checkOutput("dut8 scoreboard drained", q8.size(), 0);
    checkOutput("dut6 scoreboard drained", q6.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
